companion_action_arbiter: RTL and testbench
===========================================

COMPANION_ACTION_ARBITER -- requirements
Module: companion_action_arbiter

Interface
REQ-001 Parameter COOLDOWN_CYCLES, default 125_000_000, is the number of clk cycles after an issued action during which no new action is granted.
REQ-002 Port clk, input, 1 bit, is the single system clock.
REQ-003 Port rst, input, 1 bit, is the asynchronous active-low reset.
REQ-004 Port req, input, 3 bits, carries level requests: bit0 feed, bit1 play, bit2 clean; each is held by its requester until acknowledged.
REQ-005 Port alive, input, 1 bit, is 1 when companion health is nonzero.
REQ-006 Port ack, output, 3 bits, is a one-hot, one-cycle acknowledge for the serviced request bit.
REQ-007 Port denied, output, 1 bit, is a one-cycle flag coincident with ack when the request was dropped because alive=0.
REQ-008 Ports feed, play, clean_up, output, 1 bit each, are one-cycle action pulses to the status block.
REQ-009 Port busy, output, 1 bit, is 1 whenever the state is not IDLE.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, ISSUE and COOLDOWN.
REQ-011 In IDLE with req!=0, the block SHALL grant one bit round-robin, searching upward (wrapping bit2 to bit0) from the bit after the last granted bit.
REQ-012 After reset, bit0 has highest priority, so the last-granted pointer resets to bit2.
REQ-013 In IDLE with a grant and alive=1, the next state is ISSUE; in ISSUE, the matching action pulse and ack bit are asserted for exactly one cycle.
REQ-014 Latency from req sampled in IDLE to the action pulse SHALL be one cycle.
REQ-015 ISSUE SHALL always advance to COOLDOWN, or to IDLE when COOLDOWN_CYCLES=0.
REQ-016 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles using a 32-bit down-counter, then return to IDLE.
REQ-017 In IDLE with a grant and alive=0, the block SHALL go to ISSUE, assert ack plus denied for one cycle with no action pulse, then return directly to IDLE with no cooldown.
REQ-018 A denied grant SHALL still advance the round-robin pointer.
REQ-019 Requests arriving during ISSUE or COOLDOWN SHALL be held pending and are neither acknowledged nor lost.
REQ-020 Multiple simultaneous req bits SHALL be serviced one per grant, in round-robin order.
REQ-021 alive falling during COOLDOWN SHALL NOT shorten the cooldown.
REQ-022 alive is sampled only in IDLE at the grant.
REQ-023 At most one of feed, play and clean_up is high in any cycle, and ack is always one-hot or zero.
REQ-024 A req bit that deasserts before grant SHALL be ignored; no phantom ack is produced.

Reset
REQ-025 rst=0 SHALL asynchronously force: state IDLE; ack=0; denied=0; feed=play=clean_up=0; busy=0; cooldown counter=0; pointer=bit2.
REQ-026 Reset asserted mid-ISSUE or mid-COOLDOWN SHALL abort that operation, with no pulse emitted after reset deasserts until a fresh grant.

Configuration
REQ-027 With macro COMPANION_ARB_STATS_EN defined, the block SHALL add output ports feed_count, play_count and clean_count, 16 bits each, counting issued (non-denied) actions.
REQ-028 These counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-029 Without COMPANION_ARB_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package companion_pkg SHALL hold the state enum (IDLE, ISSUE, COOLDOWN), the action index constants (ACT_FEED=0, ACT_PLAY=1, ACT_CLEAN=2) and NUM_ACTIONS=3.
REQ-031 The round-robin selector SHALL be a sub-module, companion_rr_select: 3-bit req plus 2-bit pointer in, one-hot grant out, purely combinational.

Verification (COOLDOWN_CYCLES=4 unless stated)
REQ-032 After reset, hold req=3'b001 with alive=1 -> feed and ack=001 pulse one cycle later, busy=1 for 5 cycles, then IDLE.
REQ-033 Assert req=3'b111 and drop each bit on its ack -> grants in order feed, play, clean, with pulses spaced 6 cycles apart.
REQ-034 alive=0 with req=3'b010 -> ack=010 and denied=1 for one cycle, no play pulse, busy=0 the next cycle.
REQ-035 Assert rst=0 in the 2nd COOLDOWN cycle while req=3'b100 is held -> all outputs 0 immediately; after release, clean_up pulses 2 cycles later.
REQ-036 COOLDOWN_CYCLES=0 with req=3'b011 held -> feed, then play, each a one-cycle pulse, exactly 2 cycles apart.
REQ-037 With COMPANION_ARB_STATS_EN defined, 70000 feed grants (COOLDOWN_CYCLES=0) -> feed_count=16'hFFFF, play_count=0.

Source files
------------

// File: rtl/companion_pkg.sv
// companion_pkg: shared state encoding and action indices for the companion action arbiter
package companion_pkg;
  localparam int NUM_ACTIONS = 3;
  localparam int ACT_FEED = 0;
  localparam int ACT_PLAY = 1;
  localparam int ACT_CLEAN = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;
endpackage

// File: rtl/companion_rr_select.sv
// companion_rr_select: combinational round-robin pick; ports: req (requests), ptr (last granted index), grant (one-hot)
module companion_rr_select
  import companion_pkg::*;
(
  input  logic [NUM_ACTIONS-1:0] req,
  input  logic [1:0]             ptr,
  output logic [NUM_ACTIONS-1:0] grant
);
  always_comb
    grant = (ptr == 2'(ACT_FEED)) ? (req[ACT_PLAY]  ? 3'b010 : req[ACT_CLEAN] ? 3'b100 : req[ACT_FEED]  ? 3'b001 : 3'b000)
          : (ptr == 2'(ACT_PLAY)) ? (req[ACT_CLEAN] ? 3'b100 : req[ACT_FEED]  ? 3'b001 : req[ACT_PLAY]  ? 3'b010 : 3'b000)
          :                         (req[ACT_FEED]  ? 3'b001 : req[ACT_PLAY]  ? 3'b010 : req[ACT_CLEAN] ? 3'b100 : 3'b000);
endmodule

// File: rtl/companion_action_arbiter.sv
// companion_action_arbiter: grants feed/play/clean requests round-robin with a post-action cooldown
//   clk, rst (async active-low); req[2:0] level requests; alive companion health flag
//   ack[2:0] one-hot acknowledge; denied drop flag; feed/play/clean_up action pulses; busy not-idle
//   COMPANION_ARB_STATS_EN adds saturating 16-bit feed_count/play_count/clean_count
module companion_action_arbiter
  import companion_pkg::*;
#(
  parameter int unsigned COOLDOWN_CYCLES = 125_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ACTIONS-1:0] req,
  input  logic                   alive,
  output logic [NUM_ACTIONS-1:0] ack,
  output logic                   denied,
  output logic                   feed,
  output logic                   play,
  output logic                   clean_up,
  output logic                   busy
`ifdef COMPANION_ARB_STATS_EN
  ,
  output logic [15:0]            feed_count,
  output logic [15:0]            play_count,
  output logic [15:0]            clean_count
`endif
);
  state_t state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [1:0] ptr, ptr_nx;
  logic [NUM_ACTIONS-1:0] sel, sel_nx, grant;
  logic deny, deny_nx, act;
  companion_rr_select u_sel (.req(req), .ptr(ptr), .grant(grant));
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    ptr_nx = ptr;
    sel_nx = sel;
    deny_nx = deny;
    unique case (state)
      IDLE:
        if (grant != '0) begin
          state_nx = ISSUE;
          sel_nx = grant;
          deny_nx = ~alive;
          ptr_nx = grant[ACT_PLAY] ? 2'(ACT_PLAY) : grant[ACT_CLEAN] ? 2'(ACT_CLEAN) : 2'(ACT_FEED);
        end
      ISSUE:
        if (deny || COOLDOWN_CYCLES == 0) state_nx = IDLE;
        else begin
          state_nx = COOLDOWN;
          cnt_nx = 32'(COOLDOWN_CYCLES);
        end
      COOLDOWN: begin
        cnt_nx = cnt - 32'd1;
        state_nx = (cnt == 32'd1) ? IDLE : COOLDOWN;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= 2'(ACT_CLEAN);
      sel <= '0;
      deny <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ptr <= ptr_nx;
      sel <= sel_nx;
      deny <= deny_nx;
    end
  assign act = (state == ISSUE) & ~deny;
  assign ack = (state == ISSUE) ? sel : '0;
  assign denied = (state == ISSUE) & deny;
  assign feed = act & sel[ACT_FEED];
  assign play = act & sel[ACT_PLAY];
  assign clean_up = act & sel[ACT_CLEAN];
  assign busy = state != IDLE;
`ifdef COMPANION_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      feed_count <= '0;
      play_count <= '0;
      clean_count <= '0;
    end else begin
      if (feed && feed_count != 16'hFFFF) feed_count <= feed_count + 16'd1;
      if (play && play_count != 16'hFFFF) play_count <= play_count + 16'd1;
      if (clean_up && clean_count != 16'hFFFF) clean_count <= clean_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_companion_action_arbiter.sv
// tb_companion_action_arbiter: directed scenarios plus randomized traffic against a cycle-count model
module tb_companion_action_arbiter;
  localparam int N4 = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst4, rst0, alive4, alive0;
  logic [2:0] req4, req0, ack4, ack0;
  logic denied4, denied0, feed4, feed0, play4, play0, clean4, clean0, busy4, busy0;
  logic [7:0] o4, o0;
  int compared = 0;
  int mismatched = 0;
`ifdef COMPANION_ARB_STATS_EN
  logic [15:0] fc4, pc4, cc4, fc0, pc0, cc0;
`endif
  assign o4 = {ack4, denied4, feed4, play4, clean4, busy4};
  assign o0 = {ack0, denied0, feed0, play0, clean0, busy0};
  companion_action_arbiter #(.COOLDOWN_CYCLES(N4)) dut4 (
    .clk(clk), .rst(rst4), .req(req4), .alive(alive4), .ack(ack4), .denied(denied4),
    .feed(feed4), .play(play4), .clean_up(clean4), .busy(busy4)
`ifdef COMPANION_ARB_STATS_EN
    , .feed_count(fc4), .play_count(pc4), .clean_count(cc4)
`endif
  );
  companion_action_arbiter #(.COOLDOWN_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .alive(alive0), .ack(ack0), .denied(denied0),
    .feed(feed0), .play(play0), .clean_up(clean0), .busy(busy0)
`ifdef COMPANION_ARB_STATS_EN
    , .feed_count(fc0), .play_count(pc0), .clean_count(cc0)
`endif
  );
  task automatic do_reset;
    @(negedge clk);
    rst4 = 1'b0; rst0 = 1'b0; req4 = '0; req0 = '0; alive4 = 1'b1; alive0 = 1'b1;
    @(negedge clk);
    rst4 = 1'b1; rst0 = 1'b1;
  endtask
  task automatic test_reset;
    rst4 = 1'b0; rst0 = 1'b0; req4 = 3'b111; req0 = 3'b111; alive4 = 1'b1; alive0 = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({o4, o0} !== 16'h0) begin mismatched++; $display("FAIL reset_hold: got %b/%b expected 0", o4, o0); end
    req4 = '0; req0 = '0;
    rst4 = 1'b1; rst0 = 1'b1;
    @(negedge clk);
    compared++;
    if ({o4, o0} !== 16'h0) begin mismatched++; $display("FAIL reset_release: got %b/%b expected 0", o4, o0); end
  endtask
  task automatic test_single;
    do_reset;
    req4 = 3'b001;
    @(negedge clk);
    compared++;
    if (o4 !== 8'b001_0_100_1) begin mismatched++; $display("FAIL single_pulse: got %b expected %b", o4, 8'b001_0_100_1); end
    req4 = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      compared++;
      if (o4 !== 8'b000_0_000_1) begin mismatched++; $display("FAIL single_cooldown%0d: got %b expected %b", c, o4, 8'b000_0_000_1); end
    end
    @(negedge clk);
    compared++;
    if (o4 !== 8'h00) begin mismatched++; $display("FAIL single_idle: got %b expected 0", o4); end
  endtask
  task automatic test_round_robin;
    int n;
    int ta[3];
    logic [2:0] ga[3];
    logic [2:0] pa[3];
    n = 0;
    do_reset;
    req4 = 3'b111;
    for (int c = 1; c <= 30 && n < 3; c++) begin
      @(negedge clk);
      if (ack4 != 3'b000) begin
        ta[n] = c; ga[n] = ack4; pa[n] = {clean4, play4, feed4};
        n++;
        req4 = req4 & ~ack4;
      end
    end
    compared++;
    if (n != 3) begin mismatched++; $display("FAIL rr_count: got %0d grants expected 3", n); end
    for (int i = 0; i < n; i++) begin
      compared++;
      if (ga[i] !== 3'(1 << i) || pa[i] !== 3'(1 << i) || ta[i] !== 1 + 6 * i)
        begin mismatched++; $display("FAIL rr_grant%0d: got ack %b pulse %b cycle %0d expected %b at cycle %0d", i, ga[i], pa[i], ta[i], 3'(1 << i), 1 + 6 * i); end
    end
    req4 = '0;
  endtask
  task automatic test_denied;
    do_reset;
    alive4 = 1'b0; req4 = 3'b010;
    @(negedge clk);
    compared++;
    if (o4 !== 8'b010_1_000_1) begin mismatched++; $display("FAIL denied_ack: got %b expected %b", o4, 8'b010_1_000_1); end
    req4 = '0;
    @(negedge clk);
    compared++;
    if (o4 !== 8'h00) begin mismatched++; $display("FAIL denied_idle: got %b expected 0", o4); end
    alive4 = 1'b1; req4 = 3'b001;
    @(negedge clk);
    compared++;
    if (o4 !== 8'b001_0_100_1) begin mismatched++; $display("FAIL denied_ptr_adv: got %b expected %b", o4, 8'b001_0_100_1); end
    req4 = '0;
  endtask
  task automatic test_reset_abort;
    do_reset;
    req4 = 3'b100;
    @(negedge clk);
    compared++;
    if (o4 !== 8'b100_0_001_1) begin mismatched++; $display("FAIL abort_first: got %b expected %b", o4, 8'b100_0_001_1); end
    repeat (2) @(negedge clk);
    #1 rst4 = 1'b0;
    #1;
    compared++;
    if (o4 !== 8'h00) begin mismatched++; $display("FAIL abort_async: got %b expected 0", o4); end
    @(posedge clk);
    #1 rst4 = 1'b1;
    @(negedge clk);
    compared++;
    if (o4 !== 8'h00) begin mismatched++; $display("FAIL abort_quiet: got %b expected 0", o4); end
    @(negedge clk);
    compared++;
    if (o4 !== 8'b100_0_001_1) begin mismatched++; $display("FAIL abort_regrant: got %b expected %b", o4, 8'b100_0_001_1); end
    req4 = '0;
  endtask
  task automatic test_zero_cooldown;
    do_reset;
    req0 = 3'b011;
    @(negedge clk);
    compared++;
    if (o0 !== 8'b001_0_100_1) begin mismatched++; $display("FAIL zero_feed: got %b expected %b", o0, 8'b001_0_100_1); end
    @(negedge clk);
    compared++;
    if (o0 !== 8'h00) begin mismatched++; $display("FAIL zero_gap: got %b expected 0", o0); end
    @(negedge clk);
    compared++;
    if (o0 !== 8'b010_0_010_1) begin mismatched++; $display("FAIL zero_play: got %b expected %b", o0, 8'b010_0_010_1); end
    req0 = '0;
    @(negedge clk);
    compared++;
    if (o0 !== 8'h00) begin mismatched++; $display("FAIL zero_idle: got %b expected 0", o0); end
  endtask
`ifdef COMPANION_ARB_STATS_EN
  task automatic test_stats;
    do_reset;
    req0 = 3'b001;
    repeat (400) @(negedge clk);
    req0 = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (fc0 !== 16'd200 || pc0 !== 16'd0 || cc0 !== 16'd0) begin mismatched++; $display("FAIL stats_count: got %0d/%0d/%0d expected 200/0/0", fc0, pc0, cc0); end
    alive0 = 1'b0; req0 = 3'b010;
    @(negedge clk);
    req0 = '0; alive0 = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (pc0 !== 16'd0) begin mismatched++; $display("FAIL stats_denied: got %0d expected 0", pc0); end
  endtask
`endif
  task automatic test_random;
    int free_at, last, g;
    logic [2:0] rq, oh;
    logic al;
    logic [7:0] exp;
    do_reset;
    free_at = 0; last = 2; rq = '0; exp = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      compared++;
      if (o4 !== exp) begin mismatched++; $display("FAIL random_cycle%0d: got %b expected %b", k, o4, exp); end
      rq = rq & ~exp[7:5];
      for (int b = 0; b < 3; b++)
        if (!rq[b]) rq[b] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 15) == 0) rq[b] = 1'b0;
      al = ($urandom_range(0, 7) != 0);
      req4 = rq; alive4 = al;
      exp = '0;
      if (k >= free_at && rq != 3'b000) begin
        g = -1;
        for (int j = 1; j <= 3; j++) if (g < 0 && rq[(last + j) % 3]) g = (last + j) % 3;
        last = g;
        oh = 3'(1 << g);
        exp[7:5] = oh;
        if (al) begin
          free_at = k + 2 + N4;
          exp[3:1] = {oh[0], oh[1], oh[2]};
        end else begin
          free_at = k + 2;
          exp[4] = 1'b1;
        end
      end
      exp[0] = (k + 1) < free_at;
    end
    req4 = '0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_denied;
    test_reset_abort;
    test_zero_cooldown;
`ifdef COMPANION_ARB_STATS_EN
    test_stats;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
